// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single register-file write port between the scalar pipeline's
// write-back stage and results returned by the vector encryption coprocessor.
// Coprocessor results wait in a small FIFO. The pipeline normally wins the
// port. If a live FIFO head loses STARVE_LIMIT grants in a row, the next cycle
// forces a coprocessor write and raises wb_hold so MEM/WB freezes for a cycle.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   pipe_we     pipeline write-back request (regWrite)
//   pipe_rd     pipeline destination register
//   pipe_wd     pipeline write data
//   cop_valid   coprocessor result valid
//   cop_ready   FIFO can accept a result
//   cop_rd      coprocessor destination register
//   cop_wd      coprocessor result data
//   rf_we       register-file write enable
//   rf_wa       register-file write address
//   rf_wd       register-file write data
//   wb_hold     hold MEM/WB and re-present pipe_we next cycle
//   fifo_count  FIFO occupancy
//
// state   | meaning
// S_PIPE  | pipeline has priority; a live FIFO head takes idle port cycles
// S_FORCE | one-cycle forced coprocessor write, pipeline held
module rf_wb_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pipe_we,
    input  logic [ADDR_W-1:0]             pipe_rd,
    input  logic [DATA_W-1:0]             pipe_wd,
    input  logic                          cop_valid,
    output logic                          cop_ready,
    input  logic [ADDR_W-1:0]             cop_rd,
    input  logic [DATA_W-1:0]             cop_wd,
    output logic                          rf_we,
    output logic [ADDR_W-1:0]             rf_wa,
    output logic [DATA_W-1:0]             rf_wd,
    output logic                          wb_hold,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);

    localparam logic [0:0] S_PIPE  = 1'b0;
    localparam logic [0:0] S_FORCE = 1'b1;

    logic [ADDR_W-1:0]     mem_rd [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_wd [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_kill;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic [0:0]            state;
    logic [ST_W-1:0]       starve;
    logic [ST_W-1:0]       starve_inc;

    logic head_valid;
    logic head_kill;
    logic head_live;
    logic push;
    logic pop;
    logic pipe_gnt;
    logic cop_gnt;

    assign head_valid = (count != '0);
    assign head_kill  = mem_kill[rd_ptr];
    assign head_live  = head_valid && !head_kill;

    // reset is folded in so the port reads not-ready while reset is held
    assign cop_ready  = reset && (count < DEPTH_C);
    assign push       = cop_valid && cop_ready;

    // A killed head leaves without touching the write port
    assign pop        = cop_gnt || (head_valid && head_kill);

    assign fifo_count = count;
    assign wb_hold    = (state == S_FORCE);

    always_comb begin
        pipe_gnt = 1'b0;
        cop_gnt  = 1'b0;
        if (reset) begin
            if (state == S_FORCE) begin
                cop_gnt = head_live;
            end else if (pipe_we) begin
                pipe_gnt = 1'b1;
            end else begin
                cop_gnt = head_live;
            end
        end
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (pipe_gnt) begin
            rf_we = 1'b1;
            rf_wa = pipe_rd;
            rf_wd = pipe_wd;
        end else if (cop_gnt) begin
            rf_we = 1'b1;
            rf_wa = mem_rd[rd_ptr];
            rf_wd = mem_wd[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr] <= cop_rd;
            mem_wd[wr_ptr] <= cop_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            mem_kill <= '0;
        end else begin
            // The pipeline write is newer than any queued result to the same
            // register. Stale or empty slots may get marked too; a push clears
            // the bit again, and the push below overrides the kill so a
            // same-cycle entry survives.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (pipe_gnt && (mem_rd[i] == pipe_rd)) begin
                    mem_kill[i] <= 1'b1;
                end
            end
            if (push) begin
                mem_kill[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign starve_inc = (starve == LIMIT_C) ? starve : starve + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_PIPE;
            starve <= '0;
        end else begin
            case (state)
                S_PIPE: begin
                    if (head_live && pipe_gnt) begin
                        if (starve_inc == LIMIT_C) begin
                            state  <= S_FORCE;
                            starve <= '0;
                        end else begin
                            starve <= starve_inc;
                        end
                    end else begin
                        starve <= '0;
                    end
                end
                S_FORCE: begin
                    state  <= S_PIPE;
                    starve <= '0;
                end
                default: begin
                    state  <= S_PIPE;
                    starve <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pipe_we = 1'b0;
    logic [ADDR_W-1:0] pipe_rd = '0;
    logic [DATA_W-1:0] pipe_wd = '0;
    logic              cop_valid = 1'b0;
    logic              cop_ready;
    logic [ADDR_W-1:0] cop_rd = '0;
    logic [DATA_W-1:0] cop_wd = '0;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              wb_hold;
    logic [2:0]        fifo_count;

    rf_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .cop_valid(cop_valid), .cop_ready(cop_ready), .cop_rd(cop_rd), .cop_wd(cop_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .wb_hold(wb_hold), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              hold;
        logic              ready;
        logic [2:0]        cnt;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] wd;
        bit                kill;
    } ent_t;

    exp_t exp_q[$];

    // Reference model: queued results, force-pending flag, lost-grant tally
    ent_t mq[$];
    bit   m_force = 1'b0;
    int   m_starve = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle: apply inputs, predict this cycle's outputs, advance model
    task automatic step(input bit rst_n, input bit pwe, input logic [ADDR_W-1:0] prd,
                        input logic [DATA_W-1:0] pwd, input bit cv,
                        input logic [ADDR_W-1:0] crd, input logic [DATA_W-1:0] cwd);
        exp_t e;
        ent_t ne;
        ent_t t;
        bit   live, pg, cg, rdy;
        @(posedge clk);
        #1;
        reset     = rst_n;
        pipe_we   = pwe;
        pipe_rd   = prd;
        pipe_wd   = pwd;
        cop_valid = cv;
        cop_rd    = crd;
        cop_wd    = cwd;
        e.we = 1'b0; e.wa = '0; e.wd = '0; e.hold = 1'b0; e.ready = 1'b0; e.cnt = '0;
        if (!rst_n) begin
            mq.delete();
            m_force  = 1'b0;
            m_starve = 0;
            exp_q.push_back(e);
            return;
        end
        live = (mq.size() > 0) && !mq[0].kill;
        if (m_force) begin
            pg = 1'b0;
            cg = live;
        end else begin
            pg = pwe;
            cg = !pwe && live;
        end
        rdy = (mq.size() < DEPTH);
        if (pg) begin
            e.we = 1'b1; e.wa = prd; e.wd = pwd;
        end else if (cg) begin
            e.we = 1'b1; e.wa = mq[0].rd; e.wd = mq[0].wd;
        end
        e.hold  = m_force;
        e.ready = rdy;
        e.cnt   = 3'(mq.size());
        exp_q.push_back(e);

        if (cg || ((mq.size() > 0) && mq[0].kill)) void'(mq.pop_front());
        if (pg) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].rd == prd) begin
                    t = mq[i];
                    t.kill = 1'b1;
                    mq[i] = t;
                end
            end
        end
        if (cv && rdy) begin
            ne.rd = crd; ne.wd = cwd; ne.kill = 1'b0;
            mq.push_back(ne);
        end
        if (m_force) begin
            m_force = 1'b0;
        end else if (live && pg) begin
            m_starve++;
            if (m_starve >= LIMIT) begin
                m_force  = 1'b1;
                m_starve = 0;
            end
        end else begin
            m_starve = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we",      32'(rf_we),      32'(e.we));
                chk("rf_wa",      32'(rf_wa),      32'(e.wa));
                chk("rf_wd",      32'(rf_wd),      32'(e.wd));
                chk("wb_hold",    32'(wb_hold),    32'(e.hold));
                chk("cop_ready",  32'(cop_ready),  32'(e.ready));
                chk("fifo_count", 32'(fifo_count), 32'(e.cnt));
            end
        end
    end

    initial begin : driver
        // reset, then idle
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(5);

        // single result on an idle port
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd3, 16'h00AA);
        idle(3);

        // starvation force against continuous pipeline writes
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd5, 16'hBEEF);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'd1, 16'h1111, 1'b0, '0, '0);
        idle(2);

        // fill the FIFO under pipeline pressure, fifth push refused
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 4'd2, 16'(16'h2000 + i), 1'b1, 4'(8 + i), 16'(16'h3000 + i));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'd2, 16'h2100, 1'b0, '0, '0);
        idle(6);

        // queued r7 result superseded by a newer pipeline write to r7
        step(1'b1, 1'b1, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0001);
        step(1'b1, 1'b1, 4'd7, 16'h0002, 1'b0, '0, '0);
        idle(4);

        // simultaneous push and pop at count 2
        step(1'b1, 1'b1, 4'd0, 16'h0C00, 1'b1, 4'd9, 16'h00A0);
        step(1'b1, 1'b1, 4'd0, 16'h0C01, 1'b1, 4'd10, 16'h00A1);
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd11, 16'h00A2);
        idle(4);

        // reset while forcing with three entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 4'd0, 16'h0D00, 1'b1, 4'(12 + i), 16'(16'h0E00 + i));
        step(1'b1, 1'b1, 4'd0, 16'h0D00, 1'b0, '0, '0);
        step(1'b0, 1'b1, 4'd0, 16'h0D00, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(6);

        // randomized traffic; narrow address range so kills happen often
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 99) < 60),
                 4'($urandom_range(0, 3)),
                 16'($urandom()),
                 ($urandom_range(0, 99) < 50),
                 4'($urandom_range(0, 3)),
                 16'($urandom()));
        end
        idle(4);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back port arbiter and MEM/WB hold controller. Shares the single register-file write port between the scalar pipeline's write-back stage (MEM/WB register outputs) and results returned by the vector encryption coprocessor, which are buffered in a small FIFO. The pipeline normally has priority. A starvation counter forces a coprocessor write after a bounded wait, and asserts `wb_hold` so the pipeline freezes its MEM/WB register for that cycle.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `ADDR_W`, 4, register address width
- `FIFO_DEPTH`, 4, coprocessor result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 3, consecutive lost grants before a forced coprocessor write (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pipe_we`  in  1  write-back request from MEM/WB (regWrite)
- `pipe_rd`  in  ADDR_W  pipeline destination register
- `pipe_wd`  in  DATA_W  pipeline write data (selected result)
- `cop_valid`  in  1  coprocessor result valid
- `cop_ready`  out  1  FIFO can accept a result
- `cop_rd`  in  ADDR_W  coprocessor destination register
- `cop_wd`  in  DATA_W  coprocessor result data
- `rf_we`  out  1  register-file write enable
- `rf_wa`  out  ADDR_W  register-file write address
- `rf_wd`  out  DATA_W  register-file write data
- `wb_hold`  out  1  hold MEM/WB contents and re-present `pipe_we` next cycle
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  occupancy, for debug and hazard logic

## Operation
- FIFO push: `cop_valid && cop_ready`. `cop_ready = !reset_active && count < FIFO_DEPTH`. No same-cycle pop pass-through when full.
- Each entry holds rd, wd and a kill bit (cleared on push).
- Kill rule: when the pipeline is granted with address A, every stored entry with rd == A gets its kill bit set at the clock edge. The pipeline write is newer. An entry pushed in that same cycle is not killed.
- Killed head: popped in any cycle it is head, with no port use. At most one pop per cycle. It does not count as a pending request.
- FSM states:
  - S_PIPE:
    - Grant the pipeline if `pipe_we`. Otherwise grant the live (non-killed) FIFO head if present.
    - `wb_hold = 0`.
  - S_FORCE:
    - Grant the live FIFO head and ignore the pipeline. `wb_hold = 1`, decoded from state.
    - The next state is always S_PIPE.
    - If the head was killed on entry, nothing is written, but the hold still lasts one cycle.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments when the state is S_PIPE, a live head exists, and the pipeline is granted.
  - Clears when the head is granted or the FIFO holds no live head.
  - Transition S_PIPE→S_FORCE happens at the edge where the incremented value equals STARVE_LIMIT.
  - Counter clears on entering S_FORCE.
- Grant outputs are combinational from state, FIFO head and pipe inputs:
  - Pipeline grant: `rf_we=1, rf_wa=pipe_rd, rf_wd=pipe_wd`.
  - Coprocessor grant: head rd/wd, and the head is popped at the edge.
  - No grant: `rf_we=0`, and `rf_wa`/`rf_wd` are 0.
- Simultaneous push and pop is allowed; count is unchanged.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - FIFO empty, count 0, kill bits 0.
  - State S_PIPE, starvation counter 0.
  - `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `wb_hold=0`, `cop_ready=0`, `fifo_count=0`.
- Reset asserted mid-operation discards all queued results.
- Latency:
  - Pipeline write: 0 cycles (same cycle as `pipe_we`).
  - Coprocessor result: earliest in the cycle after push.
- Worst-case coprocessor head wait: STARVE_LIMIT+1 cycles after becoming head.
- `wb_hold` is high for exactly one cycle per force.
  - The pipeline request present during the hold is re-presented the next cycle and granted there. S_PIPE always follows S_FORCE.

## Test plan
- Reset, then 5 cycles idle:
  - All outputs 0 except `cop_ready=1` after release.
  - Push rd=3, wd=0x00AA with `pipe_we=0` → next cycle `rf_we=1, rf_wa=3, rf_wd=0x00AA`, count returns to 0.
- Continuous `pipe_we` (rd=1, wd=0x1111) while one coprocessor result (rd=5, wd=0xBEEF) is queued:
  - Pipeline granted for 3 cycles.
  - 4th cycle: `wb_hold=1`, `rf_wa=5`, `rf_wd=0xBEEF`.
  - 5th cycle: `wb_hold=0`, `rf_wa=1`.
- Fill FIFO with 4 pushes under `pipe_we=1`:
  - `cop_ready=0` at count 4, and a 5th `cop_valid` is not accepted.
  - After a forced pop, `cop_ready=1` the following cycle.
- Queue rd=7 (0x0001), then pipeline writes rd=7 (0x0002):
  - The entry is killed and popped with no write.
  - Final RF write sequence contains only 0x0002 to r7, and no force occurs.
- Simultaneous push and pop at count 2 → count stays 2; FIFO order preserved (check data order 0xA0, 0xA1, 0xA2).
- Assert `reset` low during S_FORCE with 3 entries queued:
  - Immediately `wb_hold=0`, `rf_we=0`, `fifo_count=0`.
  - After release, no stale writes appear.
